// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-fed 8N1 UART transmitter: state encoding,
// default bit period and frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic [23:0] UART_DEFAULT_CPB = 24'd868;
  localparam int          UART_FRAME_BITS  = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable 24-bit down-counter; o_tick marks the last cycle of a bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = UART_DEFAULT_CPB
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_tick
);

  logic [23:0] r_count;

  // Parks at zero when not reloaded, so it can never underflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 24'd0;
    end else if (i_load) begin
      r_count <= CLOCKS_PER_BAUD - 24'd1;
    end else if (r_count != 24'd0) begin
      r_count <= r_count - 24'd1;
    end
  end

  assign o_tick = (r_count == 24'd0);

endmodule

// File: rtl/fifo_txuart.sv
// Pops bytes from a show-ahead FIFO and sends each as an 8N1 UART frame,
// chaining frames back-to-back when the FIFO still holds data at stop-bit end.
module fifo_txuart
  import uart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = UART_DEFAULT_CPB
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_empty,
  input  logic [7:0] i_data,
  output logic       o_rd,
  output logic       o_uart_tx,
  output logic       o_busy
);

  uart_state_t r_state;
  uart_state_t w_state_next;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bit_idx;
  logic        r_tx;
  logic        r_busy;
  logic        w_tick;
  logic        w_accept;
  logic        w_load;
  logic        w_tx_next;

  uart_baud_gen #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  // Counter sits at zero in IDLE, so the tick term only matters in STOP.
  assign w_accept = !i_reset && !i_empty &&
                    ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));
  assign o_rd      = w_accept;
  assign o_uart_tx = r_tx;
  assign o_busy    = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_shreg   <= 8'd0;
      r_bit_idx <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != ST_IDLE);
      if (w_accept) begin
        r_shreg   <= i_data;
        r_bit_idx <= 3'd0;
      end else if ((r_state == ST_DATA) && w_tick) begin
        r_shreg   <= {1'b0, r_shreg[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_START;
      ST_START: if (w_tick) w_state_next = ST_DATA;
      ST_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = ST_STOP;
      ST_STOP:  if (w_tick) w_state_next = w_accept ? ST_START : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Line value for the next cycle plus baud reload on every bit boundary.
  always_comb begin
    w_tx_next = r_tx;
    w_load    = 1'b0;
    if (w_accept) begin
      w_tx_next = 1'b0;
      w_load    = 1'b1;
    end else begin
      case (r_state)
        ST_START: if (w_tick) begin
          w_tx_next = r_shreg[0];
          w_load    = 1'b1;
        end
        ST_DATA: if (w_tick) begin
          w_tx_next = (r_bit_idx == 3'd7) ? 1'b1 : r_shreg[1];
          w_load    = 1'b1;
        end
        ST_STOP: if (w_tick) w_tx_next = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
